// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// ALU operation codes and the mux-select / trap-cause encodings.
package mips_mc_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_SUBI = 6'b001011;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP,
    S_WB_R, S_WB_I
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_SLT   = 3'd2,
    ALU_FUNCT = 3'd3
  } alu_op_e;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/mips_mc_wait_timer.sv
// Memory wait-state counter: counts req-without-ready cycles and flags a
// timeout when the count reaches MAX_WAIT with ready still low (0 = never).
module mips_mc_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic ready_i,
  output logic timeout_o,
  output logic stall_o
);

  assign stall_o = req_i & ~ready_i;

  generate
    if (MAX_WAIT > 0) begin : g_timer
      localparam int CW = $clog2(MAX_WAIT + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      // Any cycle that is not a stall is either completion or outside a transfer.
      always_comb cnt_d = stall_o ? cnt_q + 1'b1 : '0;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end

      assign timeout_o = stall_o && (cnt_q == CW'(MAX_WAIT));
    end else begin : g_no_timer
      assign timeout_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM with req/ready memory handshake and sticky trap.
// Optional performance counters are built when MIPS_PERF_CNT_EN is defined.
module mips_multicycle_controller
  import mips_mc_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 3,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [OPCODE_W-1:0] opcode_i,
  input  logic                mem_ready_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic                i_or_d_o,
  output logic                ir_write_o,
  output logic                pc_write_o,
  output logic                pc_write_eq_o,
  output logic                pc_write_ne_o,
  output logic [1:0]          pc_src_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic                trap_o,
  output logic [1:0]          trap_cause_o,
  output logic [CNT_W-1:0]    instr_retired_o,
  output logic [CNT_W-1:0]    stall_cycles_o
);

  state_e     state_q, state_d;
  logic [1:0] cause_q, cause_d;
  logic [5:0] op;
  logic       timeout, stall;
  alu_op_e    alu_op;

  assign op = 6'(opcode_i);

  mips_mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (mem_req_o),
    .ready_i   (mem_ready_i),
    .timeout_o (timeout),
    .stall_o   (stall)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BOOT;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_BOOT:   state_d = S_FETCH;
      S_FETCH, S_MEM_RD, S_MEM_WR: begin
        if (mem_ready_i) begin
          state_d = (state_q == S_FETCH)  ? S_DECODE :
                    (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if (timeout) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (op)
          OP_R:                      state_d = S_EXEC_R;
          OP_ADDI, OP_SLTI, OP_SUBI: state_d = S_EXEC_I;
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:            state_d = S_BRANCH;
          OP_J:                      state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_WB_R, S_WB_I, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_BOOT;
    endcase
  end

  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    i_or_d_o      = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    pc_write_eq_o = 1'b0;
    pc_write_ne_o = 1'b0;
    pc_src_o      = PC_SRC_ALU;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = SRCB_REGB;
    alu_op        = ALU_ADD;
    reg_write_o   = 1'b0;
    reg_dst_o     = 1'b0;
    mem_to_reg_o  = 1'b0;
    trap_o        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: alu_src_b_o = SRCB_IMM_SH;
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op      = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op      = (op == OP_SLTI) ? ALU_SLT : (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
      end
      S_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      S_WB_I: reg_write_o = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        i_or_d_o  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        i_or_d_o  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a_o   = 1'b1;
        alu_op        = ALU_SUB;
        pc_src_o      = PC_SRC_ALUOUT;
        pc_write_eq_o = (op == OP_BEQ);
        pc_write_ne_o = (op == OP_BNE);
      end
      S_JUMP: begin
        pc_write_o = 1'b1;
        pc_src_o   = PC_SRC_JUMP;
      end
      S_TRAP:  trap_o = 1'b1;
      default: ;
    endcase
  end

  assign alu_op_o     = ALU_OP_W'(alu_op);
  assign trap_cause_o = cause_q;

`ifdef MIPS_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, stall_cnt_q;
  logic             retire;

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_WB_R, S_WB_I, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else if (state_q != S_TRAP) begin
      if (retire) retired_q   <= retired_q + 1'b1;
      if (stall)  stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign instr_retired_o = retired_q;
  assign stall_cycles_o  = stall_cnt_q;
`else
  logic unused_stall;
  assign unused_stall    = stall;
  assign instr_retired_o = '0;
  assign stall_cycles_o  = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Self-checking bench: builds an expected per-cycle output trace from
// instruction-level rules and compares the controller against it.
module tb_mips_multicycle_controller;
  import mips_mc_pkg::*;

  localparam int MW = 16;
  localparam int CW = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic mem_ready = 1'b0;
  logic mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_eq, pc_write_ne;
  logic [1:0] pc_src, alu_src_b, trap_cause;
  logic alu_src_a, reg_write, reg_dst, mem_to_reg, trap;
  logic [2:0] alu_op;
  logic [CW-1:0] instr_retired, stall_cycles;

  always #5 clk = ~clk;

  mips_multicycle_controller #(.OPCODE_W(6), .ALU_OP_W(3), .MAX_WAIT(MW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .i_or_d_o(i_or_d), .ir_write_o(ir_write),
    .pc_write_o(pc_write), .pc_write_eq_o(pc_write_eq), .pc_write_ne_o(pc_write_ne),
    .pc_src_o(pc_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .trap_o(trap), .trap_cause_o(trap_cause),
    .instr_retired_o(instr_retired), .stall_cycles_o(stall_cycles)
  );

  typedef struct packed {
    logic req, we, iord, irw, pcw, pceq, pcne;
    logic [1:0] pcsrc;
    logic srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic rw, rdst, m2r, trap;
    logic [1:0] cause;
  } outs_t;

  typedef struct packed {
    logic rdy;
    logic [5:0] op;
    outs_t o;
  } cyc_t;

  outs_t obs;
  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_eq, pc_write_ne, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, trap, trap_cause};

  cyc_t q[$];
  int checks = 0, failures = 0, ncyc = 0;
  int exp_ret = 0, exp_stall = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(logic rdy, logic [5:0] op, outs_t o);
    q.push_back({rdy, op, o});
  endtask

  // Non-request cycles get a random ready to show it is ignored there.
  task automatic push_r(logic [5:0] op, outs_t o);
    push(1'($urandom_range(0, 1)), op, o);
  endtask

  task automatic m_fetch(logic [5:0] op, int d);
    outs_t o;
    for (int i = 0; i <= d; i++) begin
      o = '0; o.req = 1; o.srcb = 2'b01; o.aluop = ALU_ADD;
      o.irw = (i == d); o.pcw = (i == d);
      push(i == d, op, o);
    end
    exp_stall += d;
  endtask

  task automatic m_mem(logic [5:0] op, int d);
    outs_t o;
    for (int i = 0; i <= d; i++) begin
      o = '0; o.req = 1; o.iord = 1; o.we = (op == OP_SW);
      push(i == d, op, o);
    end
    exp_stall += d;
  endtask

  task automatic m_trap(logic [5:0] op, logic [1:0] cause, int n);
    outs_t o;
    for (int i = 0; i < n; i++) begin
      o = '0; o.trap = 1; o.cause = cause;
      push_r(op, o);
    end
  endtask

  task automatic m_instr(logic [5:0] op, int df, int dm);
    outs_t o;
    logic legal;
    legal = 1'b1;
    m_fetch(op, df);
    o = '0; o.srcb = 2'b11; o.aluop = ALU_ADD; push_r(op, o);
    case (op)
      OP_R: begin
        o = '0; o.srca = 1; o.aluop = ALU_FUNCT; push_r(op, o);
        o = '0; o.rw = 1; o.rdst = 1; push_r(op, o);
      end
      OP_ADDI, OP_SLTI, OP_SUBI: begin
        o = '0; o.srca = 1; o.srcb = 2'b10;
        o.aluop = (op == OP_SLTI) ? ALU_SLT : (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
        push_r(op, o);
        o = '0; o.rw = 1; push_r(op, o);
      end
      OP_LW, OP_SW: begin
        o = '0; o.srca = 1; o.srcb = 2'b10; o.aluop = ALU_ADD; push_r(op, o);
        m_mem(op, dm);
        if (op == OP_LW) begin
          o = '0; o.rw = 1; o.m2r = 1; push_r(op, o);
        end
      end
      OP_BEQ, OP_BNE: begin
        o = '0; o.srca = 1; o.aluop = ALU_SUB; o.pcsrc = 2'b01;
        o.pceq = (op == OP_BEQ); o.pcne = (op == OP_BNE); push_r(op, o);
      end
      OP_J: begin
        o = '0; o.pcw = 1; o.pcsrc = 2'b10; push_r(op, o);
      end
      default: begin
        legal = 1'b0;
        m_trap(op, 2'b01, 20);
      end
    endcase
    if (legal) exp_ret++;
  endtask

  task automatic run();
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      @(negedge clk);
      mem_ready = c.rdy;
      opcode    = c.op;
      #1;
      chk($sformatf("cyc%0d", ncyc), obs, c.o);
      ncyc++;
    end
  endtask

  task automatic rst_assert();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rst_outs", obs, '0);
    chk("rst_ret", instr_retired, 0);
    chk("rst_stall", stall_cycles, 0);
  endtask

  // Release just after a rising edge so the next sample shows the BOOT cycle.
  task automatic rst_release();
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_ret = 0; exp_stall = 0;
    push_r(6'h00, '0);
  endtask

  task automatic chk_perf(string tag);
    @(posedge clk);
    #1;
`ifdef MIPS_PERF_CNT_EN
    chk({tag, "_ret"}, instr_retired, exp_ret);
    chk({tag, "_stall"}, stall_cycles, exp_stall);
`else
    chk({tag, "_ret"}, instr_retired, 0);
    chk({tag, "_stall"}, stall_cycles, 0);
`endif
  endtask

  logic [5:0] legal_ops [9];
  outs_t o;

  initial begin
    legal_ops = '{OP_R, OP_ADDI, OP_SLTI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};

    // Directed then random legal instruction stream.
    rst_assert(); rst_release();
    m_instr(OP_R, 0, 0);
    m_instr(OP_LW, 3, 3);
    m_instr(OP_BEQ, 0, 0);
    m_instr(OP_BNE, 0, 0);
    m_instr(OP_ADDI, 0, 0); m_instr(OP_SLTI, 1, 0); m_instr(OP_SUBI, 0, 0);
    m_instr(OP_SW, 0, 2);   m_instr(OP_J, 2, 0);
    m_instr(OP_SW, 0, MW - 1);
    m_instr(OP_LW, MW, MW);
    run();
    for (int n = 0; n < 60; n++) begin
      m_instr(legal_ops[$urandom_range(0, 8)],
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, MW) : $urandom_range(0, 3),
              ($urandom_range(0, 7) == 0) ? $urandom_range(0, MW) : $urandom_range(0, 3));
      run();
    end
    chk_perf("stream");

    // Illegal opcode ends in a sticky trap.
    rst_assert(); rst_release();
    m_instr(OP_R, 0, 0);
    m_instr(6'b111111, 0, 0);
    run();
    chk_perf("illegal");

    // Store whose ready never arrives times out.
    rst_assert(); rst_release();
    m_fetch(OP_SW, 0);
    o = '0; o.srcb = 2'b11; o.aluop = ALU_ADD; push_r(OP_SW, o);
    o = '0; o.srca = 1; o.srcb = 2'b10; o.aluop = ALU_ADD; push_r(OP_SW, o);
    o = '0; o.req = 1; o.we = 1; o.iord = 1;
    for (int i = 0; i <= MW; i++) push(1'b0, OP_SW, o);
    exp_stall += MW + 1;
    m_trap(OP_SW, 2'b10, 6);
    run();
    chk_perf("timeout");

    // Asynchronous reset in the middle of a store.
    rst_assert(); rst_release();
    m_instr(OP_R, 0, 0);
    m_fetch(OP_SW, 0);
    o = '0; o.srcb = 2'b11; o.aluop = ALU_ADD; push_r(OP_SW, o);
    o = '0; o.srca = 1; o.srcb = 2'b10; o.aluop = ALU_ADD; push_r(OP_SW, o);
    o = '0; o.req = 1; o.we = 1; o.iord = 1;
    for (int i = 0; i < 3; i++) push(1'b0, OP_SW, o);
    run();
    #1 rst_n = 1'b0;
    #1;
    chk("async_req", mem_req, 1'b0);
    chk("async_we", mem_we, 1'b0);
    chk("async_ret", instr_retired, 0);
    rst_release();
    m_instr(OP_J, 0, 0);
    run();
    chk_perf("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
